// File: rtl/regfile_port_ctrl_if.sv
// Bus bundle between the register-file port controller and its neighbours:
// ME-stage commits, debug access port and the register-file write/read-A ports.
interface regfile_port_ctrl_if;
    logic        m_valid;
    logic [5:0]  m_wbr;
    logic [31:0] m_res;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_dbg_rsel;
    logic [4:0]  rf_dbg_raddr;
    logic [31:0] rf_rdata;
    logic        stall_pipe;
    logic        init_done;
    logic        commit_lost;

    // Controller side
    modport slave (
        input  m_valid, m_wbr, m_res, dbg_req, dbg_we, dbg_addr, dbg_wdata, rf_rdata,
        output dbg_ack, dbg_rdata, rf_we, rf_waddr, rf_wdata, rf_dbg_rsel, rf_dbg_raddr,
               stall_pipe, init_done, commit_lost
    );

    // Environment side: ME stage, debug host and register-file read port
    modport master (
        output m_valid, m_wbr, m_res, dbg_req, dbg_we, dbg_addr, dbg_wdata, rf_rdata,
        input  dbg_ack, dbg_rdata, rf_we, rf_waddr, rf_wdata, rf_dbg_rsel, rf_dbg_raddr,
               stall_pipe, init_done, commit_lost
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Register-file write-port / read-port-A owner: clears the RAM after reset, forwards
// ME-stage commits, and serves debug reads/writes by stalling and draining the pipeline.
module regfile_port_ctrl #(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] INIT_VALUE   = 32'h0
) (
    input  logic          clock,
    input  logic          reset_n,
    regfile_port_ctrl_if.slave bus
);

    typedef enum logic [2:0] {INIT, IDLE, DRAIN, ACCESS, RDWAIT, ACK} state_t;

    localparam logic [4:0] DRAIN_LAST = 5'(DRAIN_CYCLES - 1);

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        commit;
    logic        lost;
    logic        stall_pipe;
    logic        init_done;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_rsel;
    logic        commit_lost;

    assign commit = bus.m_valid & bus.m_wbr[5];
    assign lost   = commit && (state inside {INIT, ACCESS, RDWAIT, ACK});

    // Write port is combinational so decode's W-stage bypass sees commits with no extra latency
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we        = commit;
        waddr     = bus.m_wbr[4:0];
        wdata     = bus.m_res;
        case (state)
            INIT: begin
                we      = 1'b1;
                waddr   = cnt;
                wdata   = INIT_VALUE;
                cnt_nxt = cnt + 5'd1;
                if (cnt == 5'd31) state_nxt = IDLE;
            end
            IDLE: begin
                if (bus.dbg_req) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = 5'd0;
                end
            end
            DRAIN: begin
                cnt_nxt = cnt + 5'd1;
                if (cnt == DRAIN_LAST) state_nxt = ACCESS;
            end
            ACCESS: begin
                // r0 is architecturally zero, so a debug write to it is swallowed
                we        = bus.dbg_we && (bus.dbg_addr != 5'd0);
                waddr     = bus.dbg_addr;
                wdata     = bus.dbg_wdata;
                state_nxt = bus.dbg_we ? ACK : RDWAIT;
            end
            RDWAIT: begin
                we        = 1'b0;
                state_nxt = ACK;
            end
            ACK: begin
                we = 1'b0;
                if (!bus.dbg_req) state_nxt = IDLE;
            end
            default: begin
                we        = 1'b0;
                state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= INIT;
            cnt         <= 5'd0;
            stall_pipe  <= 1'b1;
            init_done   <= 1'b0;
            dbg_ack     <= 1'b0;
            dbg_rdata   <= 32'h0;
            dbg_rsel    <= 1'b0;
            commit_lost <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            stall_pipe <= (state_nxt != IDLE);
            init_done  <= (state_nxt != INIT);
            dbg_ack    <= (state_nxt == ACK);
            // Read select covers the address cycle (ACCESS) and the RAM data cycle (RDWAIT)
            dbg_rsel   <= !bus.dbg_we && ((state_nxt == ACCESS) || (state_nxt == RDWAIT));
            if (state == RDWAIT)
                dbg_rdata <= (bus.dbg_addr == 5'd0) ? 32'h0 : bus.rf_rdata;
            if (lost)
                commit_lost <= 1'b1;
        end
    end

    assign bus.rf_we        = we;
    assign bus.rf_waddr     = waddr;
    assign bus.rf_wdata     = wdata;
    assign bus.rf_dbg_rsel  = dbg_rsel;
    assign bus.rf_dbg_raddr = bus.dbg_addr;
    assign bus.stall_pipe   = stall_pipe;
    assign bus.init_done    = init_done;
    assign bus.dbg_ack      = dbg_ack;
    assign bus.dbg_rdata    = dbg_rdata;
    assign bus.commit_lost  = commit_lost;

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a synchronous register-file RAM model.
module tb_regfile_port_ctrl;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    regfile_port_ctrl_if bus ();

    regfile_port_ctrl #(.DRAIN_CYCLES(3), .INIT_VALUE(32'h0)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    // Register file model: write port plus read port A with one-cycle latency
    logic [31:0] mem [32];
    always @(posedge clock) begin
        if (bus.rf_we) mem[bus.rf_waddr] <= bus.rf_wdata;
        bus.rf_rdata <= mem[bus.rf_dbg_rsel ? bus.rf_dbg_raddr : 5'd0];
    end

    typedef struct {
        logic        m_valid;
        logic [5:0]  m_wbr;
        logic [31:0] m_res;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_clear(input string tag);
        for (int i = 0; i < 32; i++) begin
            check({tag, " clear we"}, 32'(bus.rf_we), 32'd1);
            check({tag, " clear addr"}, 32'(bus.rf_waddr), i);
            check({tag, " clear data"}, bus.rf_wdata, 32'h0);
            tick();
        end
        check({tag, " init_done"}, 32'(bus.init_done), 32'd1);
        check({tag, " stall after clear"}, 32'(bus.stall_pipe), 32'd0);
        check({tag, " we after clear"}, 32'(bus.rf_we), 32'd0);
    endtask

    // Full debug access; reports ticks until ack and every rf write seen on the way
    task automatic dbg_access(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                              output int lat, output int we_cnt, output logic [4:0] wa,
                              output logic [31:0] wdt, output logic [31:0] rd);
        bus.dbg_req = 1'b1;
        bus.dbg_we = we;
        bus.dbg_addr = addr;
        bus.dbg_wdata = wd;
        lat = 0;
        we_cnt = 0;
        wa = 5'd0;
        wdt = 32'h0;
        #1;
        check("stall before access", 32'(bus.stall_pipe), 32'd0);
        while (!bus.dbg_ack && lat < 20) begin
            if (bus.rf_we) begin
                we_cnt++;
                wa = bus.rf_waddr;
                wdt = bus.rf_wdata;
            end
            tick();
            lat++;
            if (lat == 1) check("stall next cycle", 32'(bus.stall_pipe), 32'd1);
        end
        if (!bus.dbg_ack) begin
            n_checks++;
            n_fail++;
            $display("FAIL dbg ack timeout: got 0 expected 1");
        end
        rd = bus.dbg_rdata;
        bus.dbg_req = 1'b0;
        tick();
        check("ack drop", 32'(bus.dbg_ack), 32'd0);
        check("stall release", 32'(bus.stall_pipe), 32'd0);
    endtask

    int          lat, we_cnt;
    logic [4:0]  wa;
    logic [31:0] wdt, rd;

    initial begin
        vecs[0] = '{1'b1, 6'h25, 32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 6'h05, 32'h11111111, 1'b0, 5'd5,  32'h11111111};
        vecs[2] = '{1'b0, 6'h3F, 32'h22222222, 1'b0, 5'd31, 32'h22222222};
        vecs[3] = '{1'b1, 6'h3F, 32'hCAFEF00D, 1'b1, 5'd31, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 6'h20, 32'h00000001, 1'b1, 5'd0,  32'h00000001};

        bus.m_valid = 1'b0;
        bus.m_wbr = 6'h0;
        bus.m_res = 32'h0;
        bus.dbg_req = 1'b0;
        bus.dbg_we = 1'b0;
        bus.dbg_addr = 5'd0;
        bus.dbg_wdata = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst stall", 32'(bus.stall_pipe), 32'd1);
        check("rst init_done", 32'(bus.init_done), 32'd0);
        check("rst ack", 32'(bus.dbg_ack), 32'd0);
        check("rst rdata", bus.dbg_rdata, 32'h0);
        check("rst rsel", 32'(bus.rf_dbg_rsel), 32'd0);
        check("rst lost", 32'(bus.commit_lost), 32'd0);
        reset_n = 1'b1;
        run_clear("boot");

        // IDLE pass-through vectors
        for (int i = 0; i < 5; i++) begin
            bus.m_valid = vecs[i].m_valid;
            bus.m_wbr = vecs[i].m_wbr;
            bus.m_res = vecs[i].m_res;
            #1;
            check($sformatf("vec%0d we", i), 32'(bus.rf_we), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d addr", i), 32'(bus.rf_waddr), 32'(vecs[i].exp_addr));
            check($sformatf("vec%0d data", i), bus.rf_wdata, vecs[i].exp_data);
            tick();
        end
        bus.m_valid = 1'b0;
        tick();
        check("idle stall", 32'(bus.stall_pipe), 32'd0);
        check("idle lost", 32'(bus.commit_lost), 32'd0);

        // Debug write r7, then read back
        dbg_access(1'b1, 5'd7, 32'h12345678, lat, we_cnt, wa, wdt, rd);
        check("wr7 latency", lat, 5);
        check("wr7 we count", we_cnt, 1);
        check("wr7 addr", 32'(wa), 32'd7);
        check("wr7 data", wdt, 32'h12345678);
        dbg_access(1'b0, 5'd7, 32'h0, lat, we_cnt, wa, wdt, rd);
        check("rd7 latency", lat, 6);
        check("rd7 we count", we_cnt, 0);
        check("rd7 data", rd, 32'h12345678);

        // r0 stays zero even though the RAM copy holds a nonzero commit
        dbg_access(1'b1, 5'd0, 32'hFFFFFFFF, lat, we_cnt, wa, wdt, rd);
        check("wr0 latency", lat, 5);
        check("wr0 we count", we_cnt, 0);
        dbg_access(1'b0, 5'd0, 32'h0, lat, we_cnt, wa, wdt, rd);
        check("rd0 data", rd, 32'h0);

        // Commit in DRAIN passes, commit in ACK is lost; ack held while req stays high
        bus.dbg_req = 1'b1;
        bus.dbg_we = 1'b1;
        bus.dbg_addr = 5'd9;
        bus.dbg_wdata = 32'hAAAA5555;
        #1;
        tick();
        tick();
        bus.m_valid = 1'b1;
        bus.m_wbr = 6'h23;
        bus.m_res = 32'h13572468;
        #1;
        check("drain commit we", 32'(bus.rf_we), 32'd1);
        check("drain commit addr", 32'(bus.rf_waddr), 32'd3);
        check("drain commit data", bus.rf_wdata, 32'h13572468);
        tick();
        bus.m_valid = 1'b0;
        tick();
        check("access we", 32'(bus.rf_we), 32'd1);
        check("access addr", 32'(bus.rf_waddr), 32'd9);
        check("access data", bus.rf_wdata, 32'hAAAA5555);
        tick();
        check("ack set", 32'(bus.dbg_ack), 32'd1);
        check("lost before", 32'(bus.commit_lost), 32'd0);
        bus.m_valid = 1'b1;
        #1;
        check("ack commit we", 32'(bus.rf_we), 32'd0);
        tick();
        bus.m_valid = 1'b0;
        check("lost set", 32'(bus.commit_lost), 32'd1);
        check("ack held", 32'(bus.dbg_ack), 32'd1);
        tick();
        check("ack held 2", 32'(bus.dbg_ack), 32'd1);
        check("no 2nd access", 32'(bus.rf_we), 32'd0);
        bus.dbg_req = 1'b0;
        tick();
        check("ack drop 5", 32'(bus.dbg_ack), 32'd0);
        check("stall drop 5", 32'(bus.stall_pipe), 32'd0);
        check("lost sticky", 32'(bus.commit_lost), 32'd1);

        // Request withdrawn during DRAIN: read still completes with a single ack cycle
        bus.dbg_req = 1'b1;
        bus.dbg_we = 1'b0;
        bus.dbg_addr = 5'd31;
        #1;
        tick();
        tick();
        bus.dbg_req = 1'b0;
        lat = 0;
        while (!bus.dbg_ack && lat < 10) begin
            tick();
            lat++;
        end
        check("early drop ack", 32'(bus.dbg_ack), 32'd1);
        check("early drop rdata", bus.dbg_rdata, 32'hCAFEF00D);
        tick();
        check("early drop single ack", 32'(bus.dbg_ack), 32'd0);
        check("early drop idle", 32'(bus.stall_pipe), 32'd0);

        // Reset asserted while in RDWAIT
        bus.dbg_req = 1'b1;
        bus.dbg_we = 1'b0;
        bus.dbg_addr = 5'd7;
        #1;
        for (int i = 0; i < 4; i++) tick();
        check("access rsel", 32'(bus.rf_dbg_rsel), 32'd1);
        check("access raddr", 32'(bus.rf_dbg_raddr), 32'd7);
        tick();
        check("rdwait rsel", 32'(bus.rf_dbg_rsel), 32'd1);
        check("rdwait ack", 32'(bus.dbg_ack), 32'd0);
        reset_n = 1'b0;
        #1;
        check("abort ack", 32'(bus.dbg_ack), 32'd0);
        check("abort rsel", 32'(bus.rf_dbg_rsel), 32'd0);
        check("abort stall", 32'(bus.stall_pipe), 32'd1);
        check("abort init_done", 32'(bus.init_done), 32'd0);
        check("abort lost", 32'(bus.commit_lost), 32'd0);
        bus.dbg_req = 1'b0;
        tick();
        reset_n = 1'b1;
        run_clear("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
